// File: rtl/doy_to_date_if.sv
// Request/result bundle for the day-of-year to day/month converter.
// The master side issues a start with the ordinal and year; the slave side
// reports busy, a done pulse, the range-error flag and the calendar result.
interface doy_to_date_if #(
  parameter int YEAR_W = 6,
  parameter int DOY_W  = 9,
  parameter int OUT_W  = 6
);

  logic              start;
  logic [DOY_W-1:0]  in_doy;
  logic [YEAR_W-1:0] in_year;
  logic              busy;
  logic              done;
  logic              err;
  logic [OUT_W-1:0]  out_day;
  logic [OUT_W-1:0]  out_mon;

  modport master (
    output start,
    output in_doy,
    output in_year,
    input  busy,
    input  done,
    input  err,
    input  out_day,
    input  out_mon
  );

  modport slave (
    input  start,
    input  in_doy,
    input  in_year,
    output busy,
    output done,
    output err,
    output out_day,
    output out_mon
  );

endinterface

// File: rtl/doy_to_date.sv
// Iterative day-of-year to (day, month) converter for the set-date path.
// One month is peeled off per clock: the remaining ordinal is compared with
// the length of the current month and either the result is produced or the
// month length is subtracted and the month counter advances. The range check
// and the January comparison share the first cycle, so month M finishes M
// cycles after the start is accepted. A year is leap when year % 4 == 0,
// matching the day/month/year counter.
module doy_to_date #(
  parameter int YEAR_W = 6,
  parameter int DOY_W  = 9,
  parameter int OUT_W  = 6
) (
  input  logic          clk_1Hz,
  input  logic          rst,
  doy_to_date_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;

  localparam logic [DOY_W-1:0] DOY_ZERO     = DOY_W'(0);
  localparam logic [DOY_W-1:0] DOY_MAX_LEAP = DOY_W'(366);
  localparam logic [3:0]       MON_FIRST    = 4'd1;
  localparam logic [3:0]       MON_LAST     = 4'd12;

  // Number of days in month mon; February depends on the leap flag.
  function automatic logic [DOY_W-1:0] month_len(input logic [3:0] mon,
                                                 input logic       leap);
    logic [DOY_W-1:0] len;
    case (mon)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = DOY_W'(31);
      4'd4, 4'd6, 4'd9, 4'd11:                    len = DOY_W'(30);
      4'd2:                                       len = leap ? DOY_W'(29) : DOY_W'(28);
      default:                                    len = DOY_W'(31);
    endcase
    return len;
  endfunction

  // Leap decision from the low two bits of the year (year % 4 == 0).
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00);
  endfunction

  logic [1:0]       state_r,   state_s;
  logic [DOY_W-1:0] rem_r,     rem_s;
  logic [3:0]       mon_cnt_r, mon_cnt_s;
  logic             leap_r,    leap_s;
  logic             busy_r,    busy_s;
  logic             done_r,    done_s;
  logic             err_r,     err_s;
  logic [OUT_W-1:0] out_day_r, out_day_s;
  logic [OUT_W-1:0] out_mon_r, out_mon_s;

  logic [DOY_W-1:0] len_s;
  logic             range_bad_s;
  logic             fits_s;

  // Month length of the current iteration and the two decisions built on it.
  always_comb begin
    len_s       = month_len(mon_cnt_r, leap_r);
    fits_s      = (rem_r <= len_s);
    range_bad_s = (rem_r == DOY_ZERO) ||
                  (rem_r > DOY_MAX_LEAP) ||
                  ((rem_r == DOY_MAX_LEAP) && !leap_r);
  end

  // Next-state logic: accept, range check, and one month per cycle.
  always_comb begin
    state_s   = state_r;
    rem_s     = rem_r;
    mon_cnt_s = mon_cnt_r;
    leap_s    = leap_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    err_s     = err_r;
    out_day_s = out_day_r;
    out_mon_s = out_mon_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          rem_s     = bus.in_doy;
          leap_s    = is_leap(bus.in_year);
          mon_cnt_s = MON_FIRST;
          busy_s    = 1'b1;
          err_s     = 1'b0;
          state_s   = ST_CHECK;
        end else begin
          busy_s    = 1'b0;
        end
      end

      ST_CHECK: begin
        if (range_bad_s) begin
          err_s     = 1'b1;
          done_s    = 1'b1;
          out_day_s = OUT_W'(0);
          out_mon_s = OUT_W'(0);
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else if (fits_s) begin
          out_day_s = OUT_W'(rem_r);
          out_mon_s = OUT_W'(mon_cnt_r);
          done_s    = 1'b1;
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          rem_s     = rem_r - len_s;
          mon_cnt_s = mon_cnt_r + 4'd1;
          state_s   = ST_CALC;
        end
      end

      ST_CALC: begin
        if (fits_s) begin
          out_day_s = OUT_W'(rem_r);
          out_mon_s = OUT_W'(mon_cnt_r);
          done_s    = 1'b1;
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else if (mon_cnt_r >= MON_LAST) begin
          // Running past December can only come from a corrupted ordinal;
          // report it like an out-of-range input instead of wrapping.
          err_s     = 1'b1;
          done_s    = 1'b1;
          out_day_s = OUT_W'(0);
          out_mon_s = OUT_W'(0);
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          rem_s     = rem_r - len_s;
          mon_cnt_s = mon_cnt_r + 4'd1;
          state_s   = ST_CALC;
        end
      end

      default: begin
        busy_s    = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rem_r     <= DOY_ZERO;
      mon_cnt_r <= 4'd0;
      leap_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      out_day_r <= OUT_W'(0);
      out_mon_r <= OUT_W'(0);
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      mon_cnt_r <= mon_cnt_s;
      leap_r    <= leap_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      out_day_r <= out_day_s;
      out_mon_r <= out_mon_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.out_day = out_day_r;
  assign bus.out_mon = out_mon_r;

endmodule
